synapse_accumulator: RTL
========================

Name: synapse_accumulator

Overview:
- Parametrised successor of the 2-synapse accumulator. Integrates N_SYN signed multi-bit synaptic weights, gated by spikes, over a fixed-length integration window.
- Adds signed saturation, window framing, sticky overflow flag and valid/ready output handshake.
- Sits between weight memory read port and neuron/threshold stage; one instance per neuron.

Parameters:
- N_SYN, 4, synapses presented per input beat.
- W_BITS, 4, weight width per synapse, two's complement.
- ACC_W, 8, accumulator/result width, two's complement.
- WINDOW, 8, accepted beats per integration window (>=2).
- LEAK, 1, decay magnitude per beat (used only with ACC_LEAK_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- clear  in  1  synchronous: abort current window.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept beat.
- in_last  in  1  force window close on this beat.
- spk_in  in  N_SYN  spike bit per synapse.
- w_read  in  N_SYN*W_BITS  packed signed weights; synapse i at [i*W_BITS +: W_BITS].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- accumulated_potential  out  ACC_W  signed window result.
- out_sat  out  1  saturation occurred during the reported window.

Behaviour:
- Reset (reset=0, async): acc=0, beat counter=0, sat_flag=0, out_valid=0, accumulated_potential=0, out_sat=0.
- in_ready = !out_valid || out_ready (combinational). A beat is accepted when in_valid && in_ready.
- beat_sum = sum of sign-extended w_read[i] over all i with spk_in[i]=1.
- Range: N_SYN*-2^(W_BITS-1) .. N_SYN*(2^(W_BITS-1)-1). Computed at full width; no truncation.
- acc_next = acc + beat_sum at full width, then clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Clamp event sets sat_flag. sat_flag is sticky for the window.
- On accepted non-closing beat: acc <= acc_next; counter++.
- Closing beat: counter == WINDOW-1 or in_last=1.
- On an accepted closing beat, the following all happen in the next cycle:
  - accumulated_potential <= acc_next;
  - out_sat <= sat_flag | clamp_this_beat;
  - out_valid <= 1;
  - acc <= 0; counter <= 0; sat_flag <= 0.
- Latency: result visible 1 cycle after the closing beat is accepted.
- out_valid clears on out_valid && out_ready, unless a new closing beat is accepted in the same cycle, in which case it stays 1 with new data (back-to-back).
- accumulated_potential/out_sat hold stable while out_valid && !out_ready.
- in_valid=0 cycles: no state change; the counter counts accepted beats only.
- clear=1: acc, counter, sat_flag <= 0. Any beat on that cycle is discarded (clear wins, no output produced). Pending out_valid/data are unaffected.
- Reset mid-window or mid-handshake: everything returns to reset values immediately; the pending result is lost.
- Counter width: clog2(WINDOW); wraps to 0 only via closing beat.

Optional Feature:
- Macro ACC_LEAK_EN.
- Defined: on each accepted beat, acc_leaked = acc moved toward zero by LEAK, never crossing zero (|acc| <= LEAK gives 0). Then acc_next = clamp(acc_leaked + beat_sum).
- Leak does not set sat_flag.
- Undefined: no leak logic, LEAK ignored, acc_next = clamp(acc + beat_sum).

Test Plan:
- Basic (defaults): 8 beats, spk_in=4'b0011, weights {syn0=3, syn1=2, others 7}, out_ready=1 -> one out_valid pulse 1 cycle after 8th beat, accumulated_potential=40, out_sat=0.
- Saturation: 8 beats, all spikes, all weights +7 -> 127, out_sat=1. Repeat with all weights -8 -> -128, out_sat=1. Next clean window -> out_sat=0.
- Backpressure: hold out_ready=0 after a result -> in_ready=0, data held stable. Then assert out_ready together with a new closing beat -> out_valid stays 1, new value loaded next cycle.
- Early close/clear: in_last on 3rd beat with sum 5 per beat -> result 15, counter restarts. Clear on beat 4 of a later window -> no output, next 8-beat window accumulates from 0.
- Leak (ACC_LEAK_EN, LEAK=1): beat 1 = +5 on syn0, beats 2-8 spk_in=0 -> result 0. Without macro -> 5. Async reset asserted mid-window -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/synapse_accumulator.sv
// synapse_accumulator: spike-gated signed weight integrator over a beat window.
// Each accepted beat adds the sum of spiking synapse weights to a saturating
// accumulator. The window closes after WINDOW beats or on in_last, and the
// result is then offered on a valid/ready output port.
// Optional: define ACC_LEAK_EN to decay the accumulator toward zero by LEAK
// on every accepted beat, before that beat's weights are added.

// Per-synapse lane: sign-extends the weight and zeroes it when the synapse did not spike.
module synapse_lane #(
  parameter int W_BITS = 4,
  parameter int SUM_W  = 7
) (
  input  logic              spk,
  input  logic [W_BITS-1:0] w,
  output logic [SUM_W-1:0]  val
);
  assign val = spk ? {{(SUM_W-W_BITS){w[W_BITS-1]}}, w} : '0;
endmodule

module synapse_accumulator #(
  parameter int N_SYN  = 4,
  parameter int W_BITS = 4,
  parameter int ACC_W  = 8,
  parameter int WINDOW = 8,
  parameter int LEAK   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [N_SYN-1:0]          spk_in,
  input  logic [N_SYN*W_BITS-1:0]   w_read,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          accumulated_potential,
  output logic                      out_sat
);
  localparam int CNT_W = $clog2(WINDOW);
  // Wide enough for N_SYN most-negative weights with no truncation.
  localparam int SUM_W = W_BITS + $clog2(N_SYN) + 1;
  // Headroom so acc + beat_sum (and the leak step) can never wrap before clamping.
  localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 2;
  localparam logic signed [EXT_W-1:0] ACC_MAX = EXT_W'(2**(ACC_W-1) - 1);
  localparam logic signed [EXT_W-1:0] ACC_MIN = ~ACC_MAX;

  logic [N_SYN-1:0][SUM_W-1:0] lane_val;
  logic signed [SUM_W-1:0]     beat_sum;
  logic signed [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]            cnt;
  logic                        sat_flag;
  logic signed [EXT_W-1:0]     acc_ext, sum_ext, acc_base, acc_raw;
  logic [ACC_W-1:0]            acc_next;
  logic                        clamp_hit;
  logic                        accept, closing;

  for (genvar i = 0; i < N_SYN; i++) begin : g_lane
    synapse_lane #(.W_BITS(W_BITS), .SUM_W(SUM_W)) u_lane (
      .spk (spk_in[i]),
      .w   (w_read[i*W_BITS +: W_BITS]),
      .val (lane_val[i])
    );
  end

  // Adder tree over the gated lanes.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < N_SYN; i++) beat_sum = beat_sum + $signed(lane_val[i]);
  end

  assign acc_ext = {{(EXT_W-ACC_W){acc[ACC_W-1]}}, acc};
  assign sum_ext = {{(EXT_W-SUM_W){beat_sum[SUM_W-1]}}, beat_sum};

`ifdef ACC_LEAK_EN
  localparam logic signed [EXT_W-1:0] LEAK_V = EXT_W'(LEAK);
  // Decay toward zero without overshooting; small magnitudes collapse to 0.
  always_comb begin
    if (acc_ext > LEAK_V)       acc_base = acc_ext - LEAK_V;
    else if (acc_ext < -LEAK_V) acc_base = acc_ext + LEAK_V;
    else                        acc_base = '0;
  end
`else
  assign acc_base = acc_ext;
`endif

  // Full-width add, then clamp to the accumulator range and flag the event.
  always_comb begin
    acc_raw   = acc_base + sum_ext;
    acc_next  = acc_raw[ACC_W-1:0];
    clamp_hit = 1'b0;
    if (acc_raw > ACC_MAX) begin
      acc_next  = ACC_MAX[ACC_W-1:0];
      clamp_hit = 1'b1;
    end else if (acc_raw < ACC_MIN) begin
      acc_next  = ACC_MIN[ACC_W-1:0];
      clamp_hit = 1'b1;
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign closing  = (cnt == CNT_W'(WINDOW-1)) || in_last;

  // Window state and output register; a closing beat overrides the handshake clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc                   <= '0;
      cnt                   <= '0;
      sat_flag              <= 1'b0;
      out_valid             <= 1'b0;
      accumulated_potential <= '0;
      out_sat               <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (clear) begin
        acc      <= '0;
        cnt      <= '0;
        sat_flag <= 1'b0;
      end else if (accept) begin
        if (closing) begin
          accumulated_potential <= acc_next;
          out_sat               <= sat_flag | clamp_hit;
          out_valid             <= 1'b1;
          acc                   <= '0;
          cnt                   <= '0;
          sat_flag              <= 1'b0;
        end else begin
          acc      <= acc_next;
          cnt      <= cnt + 1'b1;
          sat_flag <= sat_flag | clamp_hit;
        end
      end
    end
  end
endmodule
